// File: rtl/y86_seq_ctrl.sv
// Stage sequencer for the multi-cycle sequential Y86-64 core.
// Steps each instruction through FETCH..PCUPD, owns the architectural PC,
// runs the data-memory handshake with a timeout, tracks processor status
// and keeps cycle / retired-instruction counters.
module y86_seq_ctrl #(
    parameter int              PC_W        = 64,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              CNT_W       = 32,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic [PC_W-1:0]  next_pc,
    input  logic             mem_ack,
    input  logic             dmem_error,
    output logic [PC_W-1:0]  pc,
    output logic [5:0]       stage_en,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    // Value of the wait counter during the last MEMORY cycle allowed without ack.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_MEMORY    = 4'd4,
        S_WRITEBACK = 4'd5,
        S_PCUPD     = 4'd6,
        S_HALT      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [2:0]         stat_r;
    logic [2:0]         stat_s;
    logic [TMO_W-1:0]   tmo_r;
    logic [TMO_W-1:0]   tmo_s;
    logic [3:0]         icode_r;
    logic [PC_W-1:0]    pc_r;
    logic [5:0]         stage_en_r;
    logic               mem_req_r;
    logic               halted_r;
    logic [CNT_W-1:0]   cycle_count_r;
    logic [CNT_W-1:0]   instr_count_r;

    // One-hot stage strobe for a given state; zero outside the active stages.
    function automatic logic [5:0] stage_decode(input state_t s);
        logic [5:0] v;
        case (s)
            S_FETCH:     v = 6'b000001;
            S_DECODE:    v = 6'b000010;
            S_EXECUTE:   v = 6'b000100;
            S_MEMORY:    v = 6'b001000;
            S_WRITEBACK: v = 6'b010000;
            S_PCUPD:     v = 6'b100000;
            default:     v = 6'b000000;
        endcase
        return v;
    endfunction

    // Opcodes that touch data memory: rmmovq, mrmovq, call, ret, pushq, popq.
    function automatic logic is_mem_op(input logic [3:0] ic);
        logic r;
        case (ic)
            4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: r = 1'b1;
            default:                              r = 1'b0;
        endcase
        return r;
    endfunction

    // True while an instruction is in flight (cycle_count qualifier).
    function automatic logic is_active(input state_t s);
        return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXECUTE) ||
               (s == S_MEMORY) || (s == S_WRITEBACK) || (s == S_PCUPD);
    endfunction

    // Next-state, next-status and memory wait-counter logic.
    always_comb begin
        state_s = state_r;
        stat_s  = stat_r;
        tmo_s   = tmo_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_s = S_ERR;
                    stat_s  = STAT_ADR;
                end else if (!instr_valid || (icode > 4'd11)) begin
                    state_s = S_ERR;
                    stat_s  = STAT_INS;
                end else if (icode == 4'd0) begin
                    state_s = S_HALT;
                    stat_s  = STAT_HLT;
                end else begin
                    state_s = S_DECODE;
                end
            end
            S_DECODE: begin
                state_s = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_mem_op(icode_r)) begin
                    state_s = S_MEMORY;
                    tmo_s   = '0;
                end else begin
                    state_s = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    if (dmem_error) begin
                        state_s = S_ERR;
                        stat_s  = STAT_ADR;
                    end else begin
                        state_s = S_WRITEBACK;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_s = S_ERR;
                    stat_s  = STAT_ADR;
                end else begin
                    tmo_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            S_WRITEBACK: begin
                state_s = S_PCUPD;
            end
            S_PCUPD: begin
                state_s = S_FETCH;
            end
            S_HALT: begin
                state_s = S_HALT;
            end
            S_ERR: begin
                state_s = S_ERR;
            end
            default: begin
                state_s = S_ERR;
                stat_s  = STAT_INS;
            end
        endcase
    end

    // State, status and Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            stat_r     <= STAT_AOK;
            tmo_r      <= '0;
            stage_en_r <= 6'b000000;
            mem_req_r  <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            stat_r     <= stat_s;
            tmo_r      <= tmo_s;
            stage_en_r <= stage_decode(state_s);
            mem_req_r  <= (state_s == S_MEMORY);
            halted_r   <= (state_s == S_HALT) || (state_s == S_ERR);
        end
    end

    // Opcode latch, PC register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_r       <= 4'd0;
            pc_r          <= RESET_PC;
            cycle_count_r <= '0;
            instr_count_r <= '0;
        end else begin
            if (state_r == S_FETCH) begin
                icode_r <= icode;
            end
            if (state_r == S_PCUPD) begin
                pc_r          <= next_pc;
                instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (is_active(state_r)) begin
                cycle_count_r <= cycle_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc          = pc_r;
    assign stage_en    = stage_en_r;
    assign mem_req     = mem_req_r;
    assign stat        = stat_r;
    assign halted      = halted_r;
    assign cycle_count = cycle_count_r;
    assign instr_count = instr_count_r;

endmodule
